// File: rtl/clk_switch_ctrl.sv
// Request-side sequencer for the glitch-free two-clock switch.
// It checks that clk_B is alive, drives sel, then waits a guard interval before reporting done.
module clk_switch_ctrl #(
    parameter int unsigned WIN       = 64,
    parameter int unsigned MIN_EDGES = 4,
    parameter int unsigned GUARD     = 8
) (
    input  logic clk_A,
    input  logic rstn_A,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clkb_tgl,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned GRD_W = $clog2(GUARD + 1);
    localparam int unsigned EDG_W = (MIN_EDGES > 0) ? $clog2(MIN_EDGES + 1) : 1;

    // Elaboration-time parameter sanity checks
    if (WIN < 2) begin : g_bad_win
        $error("clk_switch_ctrl: WIN must be >= 2");
    end
    if (MIN_EDGES < 1 || MIN_EDGES * 2 > WIN) begin : g_bad_edges
        $error("clk_switch_ctrl: MIN_EDGES must be in [1, WIN/2]");
    end
    if (GUARD < 6) begin : g_bad_guard
        $error("clk_switch_ctrl: GUARD must be >= 6");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SWITCH = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t             state;
    logic [WIN_W-1:0]   win_cnt;
    logic [EDG_W-1:0]   edge_cnt;
    logic [GRD_W-1:0]   guard_cnt;
    logic               tgl_s1;
    logic               tgl_s2;
    logic               tgl_h;
    logic               edge_det;
    logic               edge_final;

    // Any change between the last two synchronized samples of the clk_B/2 toggle
    assign edge_det   = tgl_s2 ^ tgl_h;
    assign edge_final = edge_det && (edge_cnt == EDG_W'(MIN_EDGES - 1));

    // Synchronizer, counters, state and registered outputs
    always_ff @(posedge clk_A or negedge rstn_A) begin
        if (!rstn_A) begin
            state     <= IDLE;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            guard_cnt <= '0;
            tgl_s1    <= 1'b0;
            tgl_s2    <= 1'b0;
            tgl_h     <= 1'b0;
            sel       <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tgl_s1 <= clkb_tgl;
            tgl_s2 <= tgl_s1;
            tgl_h  <= tgl_s2;
            done   <= 1'b0;
            err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_sel == sel) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (req_sel) begin
                            state    <= CHECK;
                            busy     <= 1'b1;
                            win_cnt  <= '0;
                            edge_cnt <= '0;
                        end else begin
                            state     <= SWITCH;
                            busy      <= 1'b1;
                            sel       <= 1'b0;
                            guard_cnt <= '0;
                        end
                    end
                end

                CHECK: begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (edge_det && (edge_cnt < EDG_W'(MIN_EDGES))) begin
                        edge_cnt <= edge_cnt + EDG_W'(1);
                    end
                    // A final edge in the expiry cycle still counts as alive
                    if (edge_final) begin
                        state     <= SWITCH;
                        sel       <= 1'b1;
                        guard_cnt <= '0;
                    end else if (win_cnt == WIN_W'(WIN - 1)) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end

                SWITCH: begin
                    guard_cnt <= guard_cnt + GRD_W'(1);
                    if (guard_cnt == GRD_W'(GUARD - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE, ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl (WIN=64, MIN_EDGES=4, GUARD=8).
module tb_clk_switch_ctrl;

    logic clk_A;
    logic rstn_A;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic clkb_tgl;
    logic sel;
    logic busy;
    logic done;
    logic err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit tgl_en = 1'b0;
    int tcnt   = 0;

    clk_switch_ctrl #(.WIN(64), .MIN_EDGES(4), .GUARD(8)) dut (
        .clk_A     (clk_A),
        .rstn_A    (rstn_A),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .clkb_tgl  (clkb_tgl),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk_A = 1'b0;
    always #5 clk_A = ~clk_A;

    // clk_B/2 stand-in: toggles every 3 clk_A cycles, away from the clk_A edge
    always @(posedge clk_A) begin
        #2;
        if (tgl_en) begin
            tcnt = tcnt + 1;
            if (tcnt == 3) begin
                tcnt     = 0;
                clkb_tgl = ~clkb_tgl;
            end
        end
    end

    task automatic step();
        @(posedge clk_A);
        #1;
    endtask

    task automatic test_reset();
        rstn_A = 1'b0;
        tgl_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b want=01000", i, {sel, req_ready, busy, done, err});
            end
        end
        rstn_A = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got=%b want=01000", i, {sel, req_ready, busy, done, err});
            end
        end
    endtask

    task automatic test_switch_to_b();
        int n;
        int noise;
        bit rose;
        req_sel   = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b00100) begin
            n_fail++;
            $display("FAIL b_check_entry got=%b want=00100", {sel, req_ready, busy, done, err});
        end
        rose  = 1'b0;
        noise = 0;
        n     = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            n = c;
            if (sel === 1'b1) begin
                rose = 1'b1;
                break;
            end
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) noise++;
        end
        n_cmp++;
        if (!rose || n < 6 || n > 20 || noise != 0) begin
            n_fail++;
            $display("FAIL b_sel_rise rose=%0b after=%0d noise=%0d want rose=1 after in 6..20 noise=0", rose, n, noise);
        end
        for (int g = 1; g <= 8; g++) begin
            step();
            n_cmp++;
            if ({sel, busy, done} !== {1'b1, (g != 8), (g == 8)}) begin
                n_fail++;
                $display("FAIL b_guard g=%0d got=%b want=%b", g, {sel, busy, done}, {1'b1, (g != 8), (g == 8)});
            end
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b11000) begin
            n_fail++;
            $display("FAIL b_return_idle got=%b want=11000", {sel, req_ready, busy, done, err});
        end
    endtask

    task automatic test_switch_to_a();
        req_sel   = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({sel, req_ready, busy, done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL a_sel_fall got=%b want=0010", {sel, req_ready, busy, done});
        end
        for (int g = 2; g <= 9; g++) begin
            step();
            n_cmp++;
            if ({sel, busy, done} !== {1'b0, (g != 9), (g == 9)}) begin
                n_fail++;
                $display("FAIL a_guard t=%0d got=%b want=%b", g, {sel, busy, done}, {1'b0, (g != 9), (g == 9)});
            end
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL a_return_idle got=%b want=01000", {sel, req_ready, busy, done, err});
        end
        // Same-source request completes immediately without touching sel
        req_sel   = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b00010) begin
            n_fail++;
            $display("FAIL a_same_done got=%b want=00010", {sel, req_ready, busy, done, err});
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL a_same_idle got=%b want=01000", {sel, req_ready, busy, done, err});
        end
    endtask

    task automatic test_liveness_fail();
        int bad;
        tgl_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        req_sel   = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bad = 0;
        for (int c = 1; c <= 64; c++) begin
            if ({sel, busy, done, err} !== 4'b0100) bad++;
            if (c != 64) step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dead_window bad_cycles=%0d want=0", bad);
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b00001) begin
            n_fail++;
            $display("FAIL dead_err got=%b want=00001", {sel, req_ready, busy, done, err});
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL dead_idle got=%b want=01000", {sel, req_ready, busy, done, err});
        end
        tgl_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit sel_exp;
        bit tgt;
        bit prev;
        bit got;
        int toggles;
        int bad_ready;
        sel_exp   = 1'b0;
        req_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tgt     = ~sel_exp;
            req_sel = tgt;
            step();
            toggles   = 0;
            bad_ready = 0;
            got       = 1'b0;
            prev      = sel_exp;
            for (int c = 1; c <= 100; c++) begin
                if (sel !== prev) toggles++;
                prev = sel;
                if (req_ready !== 1'b0) bad_ready++;
                if (done === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                req_sel = ~req_sel;
                step();
            end
            n_cmp++;
            if ({got, (toggles == 1), sel, (bad_ready == 0)} !== {1'b1, 1'b1, tgt, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_req r=%0d done=%0b toggles=%0d sel=%b bad_ready=%0d want done=1 toggles=1 sel=%b bad_ready=0",
                         r, got, toggles, sel, bad_ready, tgt);
            end
            req_sel = ~tgt;
            step();
            n_cmp++;
            if ({req_ready, busy, sel} !== {1'b1, 1'b0, tgt}) begin
                n_fail++;
                $display("FAIL b2b_idle r=%0d got=%b want=%b", r, {req_ready, busy, sel}, {1'b1, 1'b0, tgt});
            end
            sel_exp = tgt;
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_switch();
        bit rose;
        req_sel   = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rose = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (sel === 1'b1) begin
                rose = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (rose !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_sel_rise got=%b want=1", rose);
        end
        for (int i = 0; i < 3; i++) step();
        #2;
        rstn_A = 1'b0;
        #1;
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL rst_async got=%b want=01000", {sel, req_ready, busy, done, err});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL rst_hold cyc=%0d got=%b want=01000", i, {sel, req_ready, busy, done, err});
            end
        end
        rstn_A = 1'b1;
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL rst_release got=%b want=01000", {sel, req_ready, busy, done, err});
        end
        req_sel   = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rose = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (sel === 1'b1) begin
                rose = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (rose !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_retry_rise got=%b want=1", rose);
        end
        for (int g = 1; g <= 8; g++) begin
            step();
            n_cmp++;
            if ({sel, busy, done} !== {1'b1, (g != 8), (g == 8)}) begin
                n_fail++;
                $display("FAIL rst_retry_guard g=%0d got=%b want=%b", g, {sel, busy, done}, {1'b1, (g != 8), (g == 8)});
            end
        end
        step();
        n_cmp++;
        if ({sel, req_ready, busy, done, err} !== 5'b11000) begin
            n_fail++;
            $display("FAIL rst_retry_idle got=%b want=11000", {sel, req_ready, busy, done, err});
        end
    endtask

    initial begin
        rstn_A    = 1'b0;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        clkb_tgl  = 1'b0;
        test_reset();
        test_switch_to_b();
        test_switch_to_a();
        test_liveness_fail();
        test_back_to_back();
        test_reset_in_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
